packet_scheduler: RTL and testbench

Parametrised data-island packet scheduler, the successor to the fixed three-infoframe picker. It arbitrates per island slot among NUM_STREAMS streaming sources (e.g. audio clock regeneration, audio samples) and NUM_INFOFRAMES periodic InfoFrames, and emits the registered packet type that drives the header/sub mux. Beyond the fixed picker, it adds per-InfoFrame repeat periods, starvation protection for InfoFrames under heavy streaming, a request/acknowledge handshake and deadline-miss reporting. It sits in the clk_pixel domain between the packet generators and the packet assembler.

---
 rtl/hdmi_packet_pkg.sv | 20 ++
 rtl/infoframe_tracker.sv | 83 ++++++++
 rtl/packet_scheduler.sv | 166 ++++++++++++++++
 tb/tb_packet_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// hdmi_packet_pkg: shared packet-type codes and widths for the data-island
// packet scheduler and its InfoFrame trackers.
//   packet_type_t : 8-bit packet header type code
//   PKT_*         : codes of the packets the scheduler can emit
//   CNT_W         : width of the field counter and the stream-grant streak
//                   counter (PERIOD and MAX_CONSECUTIVE are limited to 1..15)
package hdmi_packet_pkg;

    typedef logic [7:0] packet_type_t;

    localparam packet_type_t PKT_NULL         = 8'h00;
    localparam packet_type_t PKT_ACR          = 8'h01;
    localparam packet_type_t PKT_AUDIO_SAMPLE = 8'h02;
    localparam packet_type_t PKT_AVI          = 8'h82;
    localparam packet_type_t PKT_SPD          = 8'h83;
    localparam packet_type_t PKT_AUDIO_INFO   = 8'h84;

    localparam int CNT_W = 4;

endpackage

// File: rtl/infoframe_tracker.sv
// infoframe_tracker: deadline bookkeeping for one periodic InfoFrame.
// Counts video fields, re-arms the frame every PERIOD fields and flags a
// missed deadline when the frame is re-armed while still untransmitted.
// Ports:
//   clk_pixel, reset_n : clock, asynchronous active-low reset
//   enable             : quasi-static InfoFrame enable
//   field_end          : one-cycle end-of-field pulse
//   grant              : the scheduler picks this frame in the current cycle
//   pending            : frame waiting for transmission
//   urgent             : pending and in the last field of its period
//   missed             : sticky deadline-miss flag
module infoframe_tracker
    import hdmi_packet_pkg::*;
#(
    parameter int PERIOD = 2
) (
    input  logic clk_pixel,
    input  logic reset_n,
    input  logic enable,
    input  logic field_end,
    input  logic grant,
    output logic pending,
    output logic urgent,
    output logic missed
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    // sent_q: transmitted since the last re-arm. Storing "sent" instead of
    // "pending" lets the reset value be a constant while pending still
    // comes out of reset equal to enable.
    logic sent_q, sent_d;
    // en_q resets high so an enabled frame is pending straight out of
    // reset; after a disable it delays re-arming by one cycle.
    logic en_q;
    logic missed_q, missed_d;
    logic wrap;

    assign pending = enable & en_q & ~sent_q;
    assign urgent  = pending & (cnt_q == LAST);
    assign missed  = missed_q;
    assign wrap    = field_end & (cnt_q == LAST);

    always_comb begin
        cnt_d    = cnt_q;
        sent_d   = sent_q;
        missed_d = missed_q;
        if (!enable) begin
            cnt_d  = '0;
            sent_d = 1'b0;
        end else begin
            if (field_end) begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            end
            // Re-arm beats a coincident grant: the frame stays pending and
            // the grant just served is not counted as a miss.
            if (wrap) begin
                sent_d = 1'b0;
                if (pending && !grant) begin
                    missed_d = 1'b1;
                end
            end else if (grant) begin
                sent_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            sent_q   <= 1'b0;
            en_q     <= 1'b1;
            missed_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sent_q   <= sent_d;
            en_q     <= enable;
            missed_q <= missed_d;
        end
    end

endmodule

// File: rtl/packet_scheduler.sv
// packet_scheduler: per-island-slot arbiter between streaming sources and
// periodic InfoFrames. On packet_enable it picks, first match wins:
//   1. lowest-index urgent InfoFrame once the stream streak hit MAX_CONSECUTIVE
//   2. highest-priority (lowest-index) requesting stream, acked
//   3. lowest-index pending InfoFrame
//   4. null packet
// Ports:
//   clk_pixel, reset_n      : clock, asynchronous active-low reset
//   video_field_end         : end-of-field pulse
//   packet_enable           : decide the next island slot
//   stream_req / stream_ack : stream request level / one-hot grant pulse
//   infoframe_enable        : per-InfoFrame enable
//   packet_type             : registered code of the current slot
//   packet_valid            : pulse when packet_type was updated
//   infoframe_missed        : sticky per-InfoFrame deadline miss
//   null_slots              : null grants of the last field (only with
//                             PACKET_SCHEDULER_STATS_EN defined)
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int                          NUM_STREAMS      = 2,
    parameter logic [NUM_STREAMS*8-1:0]    STREAM_TYPES     = {PKT_AUDIO_SAMPLE, PKT_ACR},
    parameter int                          NUM_INFOFRAMES   = 3,
    parameter logic [NUM_INFOFRAMES*8-1:0] INFOFRAME_TYPES  = {PKT_SPD, PKT_AVI, PKT_AUDIO_INFO},
    parameter int                          INFOFRAME_PERIOD = 2,
    parameter int                          MAX_CONSECUTIVE  = 4
) (
    input  logic                      clk_pixel,
    input  logic                      reset_n,
    input  logic                      video_field_end,
    input  logic                      packet_enable,
    input  logic [NUM_STREAMS-1:0]    stream_req,
    output logic [NUM_STREAMS-1:0]    stream_ack,
    input  logic [NUM_INFOFRAMES-1:0] infoframe_enable,
    output packet_type_t              packet_type,
    output logic                      packet_valid,
    output logic [NUM_INFOFRAMES-1:0] infoframe_missed
`ifdef PACKET_SCHEDULER_STATS_EN
    ,
    output logic [15:0]               null_slots
`endif
);

    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_CONSECUTIVE);

    logic [NUM_INFOFRAMES-1:0] if_pending, if_urgent, if_grant;
    logic [NUM_INFOFRAMES-1:0] urg_oh, pend_oh;
    logic [NUM_STREAMS-1:0]    req_oh;
    packet_type_t              stream_code, urg_code, pend_code;
    logic                      preempt;

    logic [CNT_W-1:0]       streak_q, streak_d;
    packet_type_t           type_q, type_d;
    logic                   valid_q;
    logic [NUM_STREAMS-1:0] ack_q, ack_d;

    for (genvar j = 0; j < NUM_INFOFRAMES; j++) begin : g_if
        infoframe_tracker #(
            .PERIOD(INFOFRAME_PERIOD)
        ) u_trk (
            .clk_pixel(clk_pixel),
            .reset_n  (reset_n),
            .enable   (infoframe_enable[j]),
            .field_end(video_field_end),
            .grant    (if_grant[j]),
            .pending  (if_pending[j]),
            .urgent   (if_urgent[j]),
            .missed   (infoframe_missed[j])
        );
    end

    // Isolate the lowest set bit: x & -x.
    assign req_oh  = stream_req & (~stream_req + NUM_STREAMS'(1));
    assign urg_oh  = if_urgent  & (~if_urgent  + NUM_INFOFRAMES'(1));
    assign pend_oh = if_pending & (~if_pending + NUM_INFOFRAMES'(1));

    always_comb begin
        stream_code = PKT_NULL;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (req_oh[i]) stream_code = STREAM_TYPES[i*8 +: 8];
        end
    end

    always_comb begin
        urg_code  = PKT_NULL;
        pend_code = PKT_NULL;
        for (int j = 0; j < NUM_INFOFRAMES; j++) begin
            if (urg_oh[j])  urg_code  = INFOFRAME_TYPES[j*8 +: 8];
            if (pend_oh[j]) pend_code = INFOFRAME_TYPES[j*8 +: 8];
        end
    end

    assign preempt = (|if_urgent) && (streak_q >= STREAK_MAX);

    always_comb begin
        type_d   = type_q;
        ack_d    = '0;
        if_grant = '0;
        streak_d = streak_q;
        if (packet_enable) begin
            if (preempt) begin
                type_d   = urg_code;
                if_grant = urg_oh;
                streak_d = '0;
            end else if (|stream_req) begin
                type_d = stream_code;
                ack_d  = req_oh;
                if (streak_q < STREAK_MAX) streak_d = streak_q + CNT_W'(1);
            end else if (|if_pending) begin
                type_d   = pend_code;
                if_grant = pend_oh;
                streak_d = '0;
            end else begin
                type_d   = PKT_NULL;
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            type_q   <= PKT_NULL;
            valid_q  <= 1'b0;
            ack_q    <= '0;
            streak_q <= '0;
        end else begin
            type_q   <= type_d;
            valid_q  <= packet_enable;
            ack_q    <= ack_d;
            streak_q <= streak_d;
        end
    end

    assign packet_type  = type_q;
    assign packet_valid = valid_q;
    assign stream_ack   = ack_q;

`ifdef PACKET_SCHEDULER_STATS_EN
    // No request and nothing pending (urgent implies pending) means null.
    logic        null_grant;
    logic [15:0] null_cnt_q, null_cnt_d, null_slots_q;

    assign null_grant = packet_enable & ~(|stream_req) & ~(|if_pending);

    always_comb begin
        null_cnt_d = null_cnt_q;
        if (null_grant && null_cnt_q != 16'hFFFF) null_cnt_d = null_cnt_q + 16'd1;
    end

    // A null grant coinciding with field_end is counted in the closing field.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            null_cnt_q   <= '0;
            null_slots_q <= '0;
        end else if (video_field_end) begin
            null_cnt_q   <= '0;
            null_slots_q <= null_cnt_d;
        end else begin
            null_cnt_q   <= null_cnt_d;
        end
    end

    assign null_slots = null_slots_q;
`endif

endmodule

// File: tb/tb_packet_scheduler.sv
// Self-checking bench for packet_scheduler: directed vector table, hand
// sequences for multi-cycle corners, then randomized traffic against a
// behavioural model. Stream 0 is given code 02 and stream 1 code 01 here.
module tb_packet_scheduler;

    localparam int PERIOD = 2;
    localparam int MAXC   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fe, pe;
    logic [1:0] req;
    logic [1:0] ack;
    logic [2:0] en;
    logic [7:0] ptype;
    logic       pvalid;
    logic [2:0] missed;
`ifdef PACKET_SCHEDULER_STATS_EN
    logic [15:0] null_slots;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    packet_scheduler #(
        .NUM_STREAMS     (2),
        .STREAM_TYPES    ({8'h01, 8'h02}),
        .NUM_INFOFRAMES  (3),
        .INFOFRAME_TYPES ({8'h83, 8'h82, 8'h84}),
        .INFOFRAME_PERIOD(PERIOD),
        .MAX_CONSECUTIVE (MAXC)
    ) dut (
        .clk_pixel       (clk),
        .reset_n         (rst_n),
        .video_field_end (fe),
        .packet_enable   (pe),
        .stream_req      (req),
        .stream_ack      (ack),
        .infoframe_enable(en),
        .packet_type     (ptype),
        .packet_valid    (pvalid),
        .infoframe_missed(missed)
`ifdef PACKET_SCHEDULER_STATS_EN
        ,
        .null_slots      (null_slots)
`endif
    );

    typedef struct {
        logic       pe;
        logic [1:0] req;
        logic [7:0] typ;
        logic       vld;
        logic [1:0] ack;
    } vec_t;

    vec_t tbl[8];

    // behavioural model state
    logic [7:0] st_code[2];
    logic [7:0] if_code[3];
    int         m_cnt[3];
    bit         m_pend[3];
    bit         m_mis[3];
    bit         m_prev_en[3];
    int         m_streak;
    logic [7:0] m_type;
    bit         m_valid;
    logic [1:0] m_ack;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs are driven at negedge; this crosses one active edge and
    // returns at the following negedge where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [2:0] en_v);
        rst_n = 1'b0;
        pe    = 1'b0;
        fe    = 1'b0;
        req   = 2'b00;
        en    = en_v;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int first_set(input logic [2:0] v);
        for (int i = 0; i < 3; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            m_cnt[j]     = 0;
            m_pend[j]    = en[j];
            m_mis[j]     = 1'b0;
            m_prev_en[j] = 1'b1;
        end
        m_streak = 0;
        m_type   = 8'h00;
        m_valid  = 1'b0;
        m_ack    = 2'b00;
    endtask

    // One clock edge of the scheduler rules, applied to the inputs present
    // at that edge. Decisions look at state from before the edge.
    task automatic model_step(input logic pe_v, input logic fe_v,
                              input logic [1:0] req_v, input logic [2:0] en_v);
        logic [2:0] eff, urg;
        int g, u, p, s;
        bit np;
        g = -1;
        for (int j = 0; j < 3; j++) begin
            eff[j] = m_pend[j] && en_v[j];
            urg[j] = eff[j] && (m_cnt[j] == PERIOD - 1);
        end
        m_valid = pe_v;
        m_ack   = 2'b00;
        if (pe_v) begin
            u = first_set(urg);
            p = first_set(eff);
            s = first_set({1'b0, req_v});
            if (u >= 0 && m_streak >= MAXC) begin
                g = u;
            end else if (s >= 0) begin
                m_ack[s] = 1'b1;
                m_type   = st_code[s];
                m_streak = (m_streak + 1 > MAXC) ? MAXC : m_streak + 1;
            end else if (p >= 0) begin
                g = p;
            end else begin
                m_type   = 8'h00;
                m_streak = 0;
            end
            if (g >= 0) begin
                m_type   = if_code[g];
                m_streak = 0;
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (!en_v[j]) begin
                m_cnt[j]  = 0;
                m_pend[j] = 1'b0;
            end else begin
                np = eff[j] && (g != j);
                if (fe_v) begin
                    m_cnt[j] = (m_cnt[j] + 1) % PERIOD;
                    if (m_cnt[j] == 0) begin
                        if (eff[j] && g != j) m_mis[j] = 1'b1;
                        np = 1'b1;
                    end
                end
                if (!m_prev_en[j]) np = 1'b1;
                m_pend[j] = np;
            end
            m_prev_en[j] = en_v[j];
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        st_code = '{8'h02, 8'h01};
        if_code = '{8'h84, 8'h82, 8'h83};

        //         pe    req     type   vld   ack
        tbl[0] = '{1'b1, 2'b00, 8'h84, 1'b1, 2'b00};
        tbl[1] = '{1'b0, 2'b00, 8'h84, 1'b0, 2'b00};
        tbl[2] = '{1'b1, 2'b00, 8'h82, 1'b1, 2'b00};
        tbl[3] = '{1'b1, 2'b00, 8'h83, 1'b1, 2'b00};
        tbl[4] = '{1'b1, 2'b00, 8'h00, 1'b1, 2'b00};
        tbl[5] = '{1'b1, 2'b11, 8'h02, 1'b1, 2'b01};
        tbl[6] = '{1'b1, 2'b10, 8'h01, 1'b1, 2'b10};
        tbl[7] = '{1'b0, 2'b10, 8'h01, 1'b0, 2'b00};

        // reset state and directed vectors
        do_reset(3'b111);
        check("reset_type",   16'(ptype),  16'h00);
        check("reset_valid",  16'(pvalid), 16'h0);
        check("reset_ack",    16'(ack),    16'h0);
        check("reset_missed", 16'(missed), 16'h0);
        for (int i = 0; i < 8; i++) begin
            pe  = tbl[i].pe;
            req = tbl[i].req;
            tick();
            check($sformatf("vec%0d_type", i),  16'(ptype),  16'(tbl[i].typ));
            check($sformatf("vec%0d_valid", i), 16'(pvalid), 16'(tbl[i].vld));
            check($sformatf("vec%0d_ack", i),   16'(ack),    16'(tbl[i].ack));
        end
        pe  = 1'b0;
        req = 2'b00;

        // starvation: all frames urgent, both streams held
        do_reset(3'b111);
        req = 2'b11;
        fe  = 1'b1;
        tick();
        fe = 1'b0;
        for (int k = 0; k < 10; k++) begin
            pe = 1'b1;
            tick();
            check($sformatf("starve%0d_type", k), 16'(ptype),
                  (k == 4) ? 16'h84 : (k == 9) ? 16'h82 : 16'h02);
            check($sformatf("starve%0d_ack", k), 16'(ack),
                  (k == 4 || k == 9) ? 16'h0 : 16'h1);
        end
        pe  = 1'b0;
        req = 2'b00;

        // two field ends without any slot: every frame misses, sticky
        do_reset(3'b111);
        fe = 1'b1;
        tick();
        fe = 1'b0;
        check("miss_after_first_fe", 16'(missed), 16'h0);
        repeat (3) tick();
        fe = 1'b1;
        tick();
        fe = 1'b0;
        check("miss_after_second_fe", 16'(missed), 16'h7);
        repeat (5) tick();
        check("miss_sticky", 16'(missed), 16'h7);

        // grant of frame 0 coincides with its re-arm
        do_reset(3'b111);
        fe = 1'b1;
        tick();
        fe = 1'b0;
        tick();
        pe = 1'b1;
        fe = 1'b1;
        tick();
        pe = 1'b0;
        fe = 1'b0;
        check("coincide_type",   16'(ptype),  16'h84);
        check("coincide_missed", 16'(missed), 16'h6);
        pe = 1'b1;
        tick();
        pe = 1'b0;
        check("coincide_rearmed", 16'(ptype), 16'h84);

        // reset arriving while a decision is in flight
        pe = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_type", 16'(ptype), 16'h00);
        @(negedge clk);
        check("inflight_valid", 16'(pvalid), 16'h0);
        check("inflight_type",  16'(ptype),  16'h00);
        pe    = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_reset_valid", 16'(pvalid), 16'h0);

`ifdef PACKET_SCHEDULER_STATS_EN
        do_reset(3'b000);
        pe = 1'b1;
        repeat (5) tick();
        pe = 1'b0;
        check("stats_before_fe", 16'(null_slots), 16'd0);
        fe = 1'b1;
        tick();
        fe = 1'b0;
        check("stats_null_slots", null_slots, 16'd5);
`endif

        // randomized traffic against the model
        do_reset(3'b111);
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            pe  = 1'($urandom_range(1));
            fe  = ($urandom_range(9) == 0);
            req = 2'($urandom_range(3));
            if ($urandom_range(49) == 0) en[$urandom_range(2)] ^= 1'b1;
            tick();
            model_step(pe, fe, req, en);
            check("rand_type",   16'(ptype),  16'(m_type));
            check("rand_valid",  16'(pvalid), 16'(m_valid));
            check("rand_ack",    16'(ack),    16'(m_ack));
            check("rand_missed", 16'(missed), 16'({m_mis[2], m_mis[1], m_mis[0]}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
